// File: rtl/sd_scaler_if.sv
// Bundle for sd_scaler_bank: sample strobe, bitstreams, scaled outputs and gain write port.
// The mute port exists only when SD_SCALER_MUTE_EN is defined.
interface sd_scaler_if #(
    parameter int N = 4,
    parameter int W = 16
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic           strobe;
    logic [N-1:0]   in;
    logic [N*W-1:0] out;
    logic           out_valid;
    logic           wr_valid;
    logic           wr_ready;
    logic [CW-1:0]  wr_ch;
    logic [W-1:0]   wr_gain;
    logic           pending;
`ifdef SD_SCALER_MUTE_EN
    logic [N-1:0]   mute;
`endif

    modport master (
`ifdef SD_SCALER_MUTE_EN
        output mute,
`endif
        output strobe, in, wr_valid, wr_ch, wr_gain,
        input  out, out_valid, wr_ready, pending
    );

    modport slave (
`ifdef SD_SCALER_MUTE_EN
        input  mute,
`endif
        input  strobe, in, wr_valid, wr_ch, wr_gain,
        output out, out_valid, wr_ready, pending
    );
endinterface

// File: rtl/sd_scaler_bank.sv
// N-channel sigma-delta bit -> +/-gain scaler with double-buffered per-channel gains.
// Optional feature macro: SD_SCALER_MUTE_EN adds a per-channel mute that forces out to 0.
module sd_scaler_bank #(
    parameter int  N = 4,
    parameter int  W = 16,
    parameter int  Q = 12,
    parameter real V = 1.0
) (
    input logic         clk,
    input logic         reset,
    sd_scaler_if.slave  bus
);
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int G0   = $rtoi(V * (2.0 ** Q));
    localparam int GMAX = (2 ** (W - 1)) - 1;
    localparam logic [W-1:0] G0_W = W'(G0);

    generate
        if (G0 < 0 || G0 > GMAX) begin : g_bad_gain
            $error("sd_scaler_bank: reset gain out of range");
        end
    endgenerate

    logic         wr_accept;
    logic [W-1:0] wr_gain_clamped;
    logic         pending_reg;
    logic         out_valid_reg;
    logic [W-1:0] act_reg [N];
    logic [W-1:0] shd_reg [N];
    logic [W-1:0] out_reg [N];
    logic         pend_reg [N];

    // Writes are refused on strobe cycles so a commit never races a shadow update.
    assign bus.wr_ready = !bus.strobe;
    assign wr_accept    = bus.wr_valid && !bus.strobe;
    // Clamping to +max keeps the negated gain representable.
    assign wr_gain_clamped = bus.wr_gain[W-1] ? {1'b0, {(W-1){1'b1}}} : bus.wr_gain;

    assign bus.out_valid = out_valid_reg;
    assign bus.pending   = pending_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            pending_reg   <= 1'b0;
        end else begin
            out_valid_reg <= bus.strobe;
            if (bus.strobe)
                pending_reg <= 1'b0;
            else if (wr_accept && int'(bus.wr_ch) < N)
                pending_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            logic [W-1:0] geff;
            logic         muted;

            // Gain in effect for this strobe, including a commit happening now.
            assign geff = pend_reg[gi] ? shd_reg[gi] : act_reg[gi];
`ifdef SD_SCALER_MUTE_EN
            assign muted = bus.mute[gi];
`else
            assign muted = 1'b0;
`endif
            assign bus.out[gi*W +: W] = out_reg[gi];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    act_reg[gi]  <= G0_W;
                    shd_reg[gi]  <= G0_W;
                    pend_reg[gi] <= 1'b0;
                    out_reg[gi]  <= '0;
                end else if (bus.strobe) begin
                    act_reg[gi]  <= geff;
                    pend_reg[gi] <= 1'b0;
                    if (muted)
                        out_reg[gi] <= '0;
                    else
                        out_reg[gi] <= bus.in[gi] ? geff : (~geff + 1'b1);
                end else if (wr_accept && bus.wr_ch == CW'(gi)) begin
                    shd_reg[gi]  <= wr_gain_clamped;
                    pend_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_sd_scaler_bank.sv
// Randomized and directed bench for sd_scaler_bank against a gain/commit reference model.
// Build with SD_SCALER_MUTE_EN defined to also exercise the mute feature.
module tb_sd_scaler_bank;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int Q  = 12;
    localparam int CW = 2;
`ifdef SD_SCALER_MUTE_EN
    localparam bit MUTE_EN = 1'b1;
`else
    localparam bit MUTE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sd_scaler_if #(.N(N), .W(W)) bus ();

    sd_scaler_bank #(.N(N), .W(W), .Q(Q), .V(1.0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: integer gains and expected signed outputs.
    int ma [N];
    int ms [N];
    bit mp [N];
    int mo [N];
    bit mv;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            ma[c] = 4096;
            ms[c] = 4096;
            mp[c] = 1'b0;
            mo[c] = 0;
        end
        mv = 1'b0;
    endtask

    function automatic bit model_pending();
        bit p = 1'b0;
        for (int c = 0; c < N; c++) p |= mp[c];
        return p;
    endfunction

    task automatic check_outs(input string tag);
        for (int c = 0; c < N; c++)
            check($sformatf("%s_out%0d", tag, c), 64'(bus.out[c*W +: W]), 64'(mo[c] & 32'hFFFF));
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(mv));
        check({tag, "_pending"}, 64'(bus.pending), 64'(model_pending()));
    endtask

    task automatic drive(input bit stb, input logic [N-1:0] inb, input logic [N-1:0] mt,
                         input bit wv, input int ch, input int gain);
        bus.strobe   = stb;
        bus.in       = inb;
        bus.wr_valid = wv;
        bus.wr_ch    = CW'(ch);
        bus.wr_gain  = W'(gain);
`ifdef SD_SCALER_MUTE_EN
        bus.mute     = mt;
`endif
    endtask

    // One clock cycle: drive, check wr_ready, clock, update model, check outputs.
    task automatic cycle(input string tag, input bit stb, input logic [N-1:0] inb,
                         input logic [N-1:0] mt, input bit wv, input int ch, input int gain);
        int g;
        drive(stb, inb, mt, wv, ch, gain);
        #1;
        check({tag, "_wr_ready"}, 64'(bus.wr_ready), 64'(!stb));
        $display("[TB] %s stb=%0b in=%b wr=%0b ch=%0d gain=0x%04h", tag, stb, inb, wv, ch, gain);
        @(posedge clk);
        if (stb) begin
            mv = 1'b1;
            for (int c = 0; c < N; c++) begin
                g = mp[c] ? ms[c] : ma[c];
                ma[c] = g;
                mp[c] = 1'b0;
                if (MUTE_EN && mt[c]) mo[c] = 0;
                else mo[c] = inb[c] ? g : -g;
            end
        end else begin
            mv = 1'b0;
            if (wv && ch < N) begin
                ms[ch] = (gain >= 32768) ? 32767 : gain;
                mp[ch] = 1'b1;
            end
        end
        #1;
        check_outs(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b1, 0, 16'h0123);
        @(posedge clk);
        #1;
        model_reset();
        check_outs(tag);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 0, 0);
        model_reset();
        #1;
        check_outs("async_reset");
        do_reset("reset");

        // Basic strobe from reset gain
        cycle("idle", 1'b0, 4'b0101, '0, 1'b0, 0, 0);
        check("idle_zero", 64'(bus.out), 64'h0);
        cycle("t1", 1'b1, 4'b0101, '0, 1'b0, 0, 0);
        check("t1_ch0", 64'(bus.out[15:0]), 64'h1000);
        check("t1_ch1", 64'(bus.out[31:16]), 64'hF000);
        cycle("t1_after", 1'b0, 4'b0000, '0, 1'b0, 0, 0);

        // Shadow write then commit
        cycle("t2_wr", 1'b0, 4'b0000, '0, 1'b1, 2, 16'h0800);
        check("t2_pend", 64'(bus.pending), 64'h1);
        cycle("t2_stb", 1'b1, 4'b0100, '0, 1'b0, 0, 0);
        check("t2_ch2", 64'(bus.out[47:32]), 64'h0800);
        check("t2_ch3", 64'(bus.out[63:48]), 64'hF000);

        // Clamp
        cycle("t3_wr", 1'b0, 4'b0000, '0, 1'b1, 1, 16'h9000);
        cycle("t3_stb", 1'b1, 4'b0000, '0, 1'b0, 0, 0);
        check("t3_neg", 64'(bus.out[31:16]), 64'h8001);
        cycle("t3_stb2", 1'b1, 4'b0010, '0, 1'b0, 0, 0);
        check("t3_pos", 64'(bus.out[31:16]), 64'h7FFF);

        // Write held across a strobe cycle
        cycle("t4_blk", 1'b1, 4'b0001, '0, 1'b1, 0, 16'h0123);
        cycle("t4_acc", 1'b0, 4'b0001, '0, 1'b1, 0, 16'h0123);
        cycle("t4_stb", 1'b1, 4'b0001, '0, 1'b0, 0, 0);
        check("t4_ch0", 64'(bus.out[15:0]), 64'h0123);

        // Last write wins, reset discards shadow
        cycle("t5_wa", 1'b0, 4'b0000, '0, 1'b1, 0, 16'h0100);
        cycle("t5_wb", 1'b0, 4'b0000, '0, 1'b1, 0, 16'h0200);
        cycle("t5_stb", 1'b1, 4'b0001, '0, 1'b0, 0, 0);
        check("t5_ch0", 64'(bus.out[15:0]), 64'h0200);
        cycle("t6_wr", 1'b0, 4'b0000, '0, 1'b1, 0, 16'h0400);
        do_reset("t6_rst");
        check("t6_pend", 64'(bus.pending), 64'h0);
        cycle("t6_stb", 1'b1, 4'b0001, '0, 1'b0, 0, 0);
        check("t6_ch0", 64'(bus.out[15:0]), 64'h1000);

        if (MUTE_EN) begin
            cycle("t7_mute", 1'b1, 4'b1111, 4'b0010, 1'b0, 0, 0);
            check("t7_ch1", 64'(bus.out[31:16]), 64'h0000);
            check("t7_ch0", 64'(bus.out[15:0]), 64'h1000);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd_rst");
            end else begin
                cycle("rnd", ($urandom_range(0, 2) == 0), N'($urandom),
                      MUTE_EN ? N'($urandom) : '0, $urandom_range(0, 1),
                      $urandom_range(0, N - 1), $urandom_range(0, 65535));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sd_scaler_bank.md
# sd_scaler_bank

Multi-channel sigma-delta bitstream scaler: each of N 1-bit modulator streams is mapped to a registered signed fixed-point value of +G or −G on every sample strobe. Each channel has its own gain, programmable at run time through a valid/ready write port. Writes are double-buffered and committed atomically on the next strobe. Sits between the sigma-delta modulator outputs and the downstream fixed-point filter/accumulator datapath, replacing per-channel fixed-gain bipolar muxes.

## Interface
- N, default 4: channel count, ≥1.
- W, default 16: output/gain width, two's complement.
- Q, default 12: fractional bits.
- V, default 1.0 (real): reset gain. G0 = $rtoi(V·2**Q); elaboration error if G0 < 0 or G0 > 2**(W−1)−1.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- strobe  in  1  sample enable, one clk cycle per modulator sample.
- in  in  N  bitstream bit per channel; 1 → +G, 0 → −G.
- out  out  N·W  packed; channel c at [c·W +: W], signed.
- out_valid  out  1  one-cycle pulse when out updates.
- wr_valid  in  1  gain write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_ch  in  $clog2(N) (min 1)  target channel; values ≥ N are accepted and discarded.
- wr_gain  in  W  unsigned gain magnitude.
- pending  out  1  OR of all per-channel commit-pending flags.

## Operation
- Per channel: active gain A[c], shadow gain S[c], and pending flag P[c].
- Accepted write: S[wr_ch] ← clamp(wr_gain), P[wr_ch] ← 1. clamp: if the MSB of wr_gain is set, the result is 2**(W−1)−1; otherwise it is wr_gain unchanged. This keeps −G representable.
- Repeated writes to one channel before a strobe: last write wins.
- wr_ready = !strobe (combinational). No write is accepted on a strobe cycle, so a commit never races a write.
- On a strobe cycle, for every channel:
  - if P[c] is set: A[c] ← S[c] and P[c] ← 0;
  - then out[c] ← in[c] ? +Geff : −Geff, where Geff is the gain in effect after the commit (S[c] if P[c] is set, otherwise A[c]);
  - −G is formed as two's complement (~G + 1) at width W. G = 0 gives 0 for both in values.
- No strobe: out holds its value and A is unchanged.
- Reset values:
  - out all zeros, out_valid 0, pending 0;
  - A[c] = S[c] = G0, P[c] = 0;
  - wr_ready follows !strobe; writes during reset are ignored.
- Reset mid-operation discards all shadow writes and pending flags and restores G0.

## Timing
- Input to output latency: in is sampled at the clk edge ending the strobe cycle. out and out_valid are visible in the following cycle.
- out_valid is high for exactly one cycle per strobe. Back-to-back strobes give out_valid high continuously.
- A write accepted in cycle t takes effect at the first strobe in a cycle ≥ t+1. pending rises in cycle t+1.
- pending falls in the cycle after the committing strobe, the same cycle the new out appears.
- All outputs are registered except wr_ready.

## Configuration
- SD_SCALER_MUTE_EN defined:
  - adds input port mute [N−1:0];
  - on a strobe, a muted channel loads out[c] ← 0 regardless of in[c];
  - gain commit still occurs;
  - out_valid still pulses.
- SD_SCALER_MUTE_EN undefined: no mute port. After the first strobe, out is always ±G.

## Test plan
All scenarios use W=16, Q=12, V=1.0, so G0 = 0x1000.
- Reset state, then strobe with in=4'b0101:
  - before the strobe: out all 0x0000, out_valid 0;
  - one cycle after the strobe: ch0=0x1000, ch1=0xF000, ch2=0x1000, ch3=0xF000, out_valid high for 1 cycle.
- Write ch2 gain 0x0800 with no strobe: out unchanged, pending=1. Next strobe with in[2]=1, in[3]=0: ch2=0x0800, ch3=0xF000, pending=0.
- Write ch1 gain 0x9000 (clamped to 0x7FFF), then strobe with in[1]=0: ch1=0x8001. A second strobe with in[1]=1 gives ch1=0x7FFF.
- wr_valid asserted on a strobe cycle: wr_ready=0 and no write. wr_valid held into the next cycle: accepted there, committed at the following strobe.
- Two writes to ch0 (0x0100, then 0x0200) before a strobe: the strobe with in[0]=1 yields 0x0200. Write ch0 0x0400 then assert reset before any strobe: pending=0, and the next strobe yields 0x1000.
- With SD_SCALER_MUTE_EN: mute=4'b0010 with in=4'b1111 → ch1=0x0000, the other channels 0x1000, and out_valid pulses.
